// File: rtl/dice_roll_arbiter.sv
// Round-robin arbiter that lends one dice roller to N_REQ requesters: tumble, settle,
// sample (retrying on illegal faces) and return a tagged result over valid/ready.
module dice_roll_arbiter #(
  parameter int N_REQ     = 4,
  parameter int IDW       = 2,
  parameter int TUMBLE    = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_REQ-1:0] i_req,
  output logic [N_REQ-1:0] o_gnt,
  output logic             o_busy,
  output logic             o_dice_en,
  input  logic [2:0]       i_dice_val,
  output logic             o_roll_valid,
  input  logic             i_roll_ready,
  output logic [IDW-1:0]   o_roll_id,
  output logic [2:0]       o_roll_value,
  output logic             o_roll_err,
  output logic [1:0]       o_state
);

  localparam int CW = (TUMBLE > 1) ? $clog2(TUMBLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TUMBLE = 2'd1,
    S_SETTLE = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t           r_state, w_nxt_state;
  logic [IDW-1:0]   r_ptr, w_nxt_ptr;
  logic [CW-1:0]    r_cnt, w_nxt_cnt;
  logic [3:0]       r_retry, w_nxt_retry;
  logic [N_REQ-1:0] r_gnt, w_nxt_gnt;
  logic             r_busy, w_nxt_busy;
  logic             r_dice_en, w_nxt_dice_en;
  logic             r_valid, w_nxt_valid;
  logic [IDW-1:0]   r_id, w_nxt_id;
  logic [2:0]       r_value, w_nxt_value;
  logic             r_err, w_nxt_err;

  logic             w_found;
  logic [IDW-1:0]   w_win;
  logic [IDW-1:0]   w_idx;
  logic             w_legal;

  // Search starts just after the last served requester, so it has lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = IDW'((int'(r_ptr) + k) % N_REQ);
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_legal = (i_dice_val >= 3'd1) && (i_dice_val <= 3'd6);

  // Result handshake: o_roll_valid rises with the result fields and holds them
  // unchanged until a cycle with i_roll_ready=1; that edge completes the transfer.
  // i_roll_ready is ignored while o_roll_valid=0.
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_ptr     = r_ptr;
    w_nxt_cnt     = r_cnt;
    w_nxt_retry   = r_retry;
    w_nxt_gnt     = r_gnt;
    w_nxt_dice_en = r_dice_en;
    w_nxt_valid   = r_valid;
    w_nxt_id      = r_id;
    w_nxt_value   = r_value;
    w_nxt_err     = r_err;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_nxt_state   = S_TUMBLE;
          w_nxt_gnt     = {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
          w_nxt_id      = w_win;
          w_nxt_cnt     = '0;
          w_nxt_retry   = '0;
          w_nxt_dice_en = 1'b1;
        end
      end
      S_TUMBLE: begin
        if (r_cnt == CW'(TUMBLE - 1)) begin
          w_nxt_state   = S_SETTLE;
          w_nxt_dice_en = 1'b0;
        end else begin
          w_nxt_cnt = r_cnt + 1'b1;
        end
      end
      S_SETTLE: begin
        if (w_legal) begin
          w_nxt_state = S_RESP;
          w_nxt_value = i_dice_val;
          w_nxt_err   = 1'b0;
          w_nxt_valid = 1'b1;
        end else if (r_retry < 4'(MAX_RETRY)) begin
          w_nxt_state   = S_TUMBLE;
          w_nxt_retry   = r_retry + 4'd1;
          w_nxt_cnt     = '0;
          w_nxt_dice_en = 1'b1;
        end else begin
          w_nxt_state = S_RESP;
          w_nxt_value = 3'd0;
          w_nxt_err   = 1'b1;
          w_nxt_valid = 1'b1;
        end
      end
      S_RESP: begin
        if (i_roll_ready) begin
          w_nxt_state = S_IDLE;
          w_nxt_valid = 1'b0;
          w_nxt_gnt   = '0;
          w_nxt_ptr   = r_id;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
    w_nxt_busy = (w_nxt_state != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= IDW'(N_REQ - 1);
      r_cnt     <= '0;
      r_retry   <= '0;
      r_gnt     <= '0;
      r_busy    <= 1'b0;
      r_dice_en <= 1'b0;
      r_valid   <= 1'b0;
      r_id      <= '0;
      r_value   <= 3'd0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_ptr     <= w_nxt_ptr;
      r_cnt     <= w_nxt_cnt;
      r_retry   <= w_nxt_retry;
      r_gnt     <= w_nxt_gnt;
      r_busy    <= w_nxt_busy;
      r_dice_en <= w_nxt_dice_en;
      r_valid   <= w_nxt_valid;
      r_id      <= w_nxt_id;
      r_value   <= w_nxt_value;
      r_err     <= w_nxt_err;
    end
  end

  assign o_gnt        = r_gnt;
  assign o_busy       = r_busy;
  assign o_dice_en    = r_dice_en;
  assign o_roll_valid = r_valid;
  assign o_roll_id    = r_id;
  assign o_roll_value = r_value;
  assign o_roll_err   = r_err;
  assign o_state      = r_state;

endmodule

// File: tb/tb_dice_roll_arbiter.sv
// Directed and randomized rolls against a round-robin / retry reference model;
// the bench plays the dice roller and chooses the face seen in each settle cycle.
module tb_dice_roll_arbiter;

  localparam int N_REQ     = 4;
  localparam int IDW       = 2;
  localparam int TUMBLE    = 8;
  localparam int MAX_RETRY = 3;

  logic             clk;
  logic             rst_n;
  logic [N_REQ-1:0] i_req;
  logic [N_REQ-1:0] o_gnt;
  logic             o_busy;
  logic             o_dice_en;
  logic [2:0]       i_dice_val;
  logic             o_roll_valid;
  logic             i_roll_ready;
  logic [IDW-1:0]   o_roll_id;
  logic [2:0]       o_roll_value;
  logic             o_roll_err;
  logic [1:0]       o_state;

  int n_vec;
  int n_err;
  int m_ptr;
  logic [5:0] exp_q[$];

  dice_roll_arbiter #(
    .N_REQ(N_REQ), .IDW(IDW), .TUMBLE(TUMBLE), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(i_req), .o_gnt(o_gnt), .o_busy(o_busy),
    .o_dice_en(o_dice_en), .i_dice_val(i_dice_val), .o_roll_valid(o_roll_valid),
    .i_roll_ready(i_roll_ready), .o_roll_id(o_roll_id), .o_roll_value(o_roll_value),
    .o_roll_err(o_roll_err), .o_state(o_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // reference model: first requester after ptr, wrapping around
  function automatic int rr_pick(input int ptr, input logic [N_REQ-1:0] req_v);
    for (int k = 1; k <= N_REQ; k++) begin
      if (req_v[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
    end
    return -1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt"}, o_gnt, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_dice_en"}, o_dice_en, 0);
    chk({tag, "_valid"}, o_roll_valid, 0);
    chk({tag, "_id"}, o_roll_id, 0);
    chk({tag, "_value"}, o_roll_value, 0);
    chk({tag, "_err"}, o_roll_err, 0);
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    m_ptr = N_REQ - 1;
  endtask

  // One full roll: n_bad illegal settle samples precede the legal one.
  task automatic run_roll(input logic [N_REQ-1:0] req_v, input int n_bad, input int ready_wait);
    int win;
    int nwin;
    logic [2:0] plan[MAX_RETRY+2];
    logic exp_err;
    logic [2:0] exp_val;
    logic [5:0] exp_rec;
    win     = rr_pick(m_ptr, req_v);
    nwin    = (n_bad > MAX_RETRY) ? MAX_RETRY + 1 : n_bad + 1;
    exp_err = (n_bad > MAX_RETRY);
    for (int w = 0; w < nwin; w++)
      plan[w] = (w < n_bad) ? (($urandom_range(0, 1) == 1) ? 3'd7 : 3'd0)
                            : 3'($urandom_range(1, 6));
    exp_val = exp_err ? 3'd0 : plan[nwin-1];
    exp_q.push_back({2'(win), exp_val, exp_err});

    i_req      = req_v;
    i_dice_val = 3'($urandom);
    step();
    chk("grant", o_gnt, 32'd1 << win);
    chk("busy_roll", o_busy, 1);
    i_req = N_REQ'($urandom);
    for (int c = 1; c <= nwin * (TUMBLE + 1); c++) begin
      int p;
      int w;
      p = (c - 1) % (TUMBLE + 1);
      w = (c - 1) / (TUMBLE + 1);
      chk("dice_en", o_dice_en, (p < TUMBLE) ? 1 : 0);
      chk("valid_early", o_roll_valid, 0);
      chk("gnt_hold", o_gnt, 32'd1 << win);
      i_dice_val   = (p == TUMBLE) ? plan[w] : 3'($urandom);
      i_roll_ready = 1'($urandom);
      step();
    end
    i_roll_ready = 1'b0;
    chk("valid_rise", o_roll_valid, 1);
    chk("dice_en_resp", o_dice_en, 0);
    chk("queue_nonempty", exp_q.size(), 1);
    exp_rec = (exp_q.size() > 0) ? exp_q.pop_front() : 6'h3f;
    chk("result", {o_roll_id, o_roll_value, o_roll_err}, exp_rec);
    repeat (ready_wait) begin
      i_dice_val = 3'($urandom);
      step();
      chk("resp_valid", o_roll_valid, 1);
      chk("resp_stable", {o_roll_id, o_roll_value, o_roll_err}, exp_rec);
      chk("resp_gnt", o_gnt, 32'd1 << win);
      chk("resp_dice_en", o_dice_en, 0);
    end
    i_roll_ready = 1'b1;
    step();
    i_roll_ready = 1'b0;
    chk("valid_drop", o_roll_valid, 0);
    chk("gnt_drop", o_gnt, 0);
    chk("idle_busy", o_busy, 0);
    m_ptr = win;
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    i_req        = '0;
    i_dice_val   = 3'd0;
    i_roll_ready = 1'b0;
    rst_n        = 1'b0;
    @(negedge clk);
    apply_reset(3);

    // idle with no requests
    repeat (3) begin
      step();
      chk("idle_quiet_busy", o_busy, 0);
      chk("idle_quiet_gnt", o_gnt, 0);
    end

    run_roll(4'b0100, 0, 0);   // single requester, plain latency
    run_roll(4'b0010, 0, 5);   // consumer stalls in RESP
    run_roll(4'b1000, 4, 0);   // every sample illegal: error result
    run_roll(4'b0001, 3, 1);   // legal only on the last allowed retry
    run_roll(4'b0001, 1, 0);   // one retry

    // fairness with all requests held
    apply_reset(1);
    repeat (6) run_roll(4'b1111, 0, 0);

    // reset in the third tumble cycle aborts the roll
    i_req = 4'b0100;
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    check_reset_outputs("midroll_reset");
    rst_n = 1'b1;
    m_ptr = N_REQ - 1;
    run_roll(4'b1111, 0, 0);
    run_roll(4'b0001, 0, 0);

    repeat (24)
      run_roll(N_REQ'($urandom_range(1, 15)), $urandom_range(0, 5), $urandom_range(0, 3));

    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
